// File: rtl/intc_responder.sv
// CPU-side interrupt responder: accepts IRQ at an instruction boundary, acknowledges, vectors and returns.
// Optional nesting (second level) is enabled by defining INTC_RESP_NEST_EN.
module intc_responder #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IRQ,
  input  logic [ADDR_W-1:0] isr_addr,
  input  logic              int_en,
  input  logic              instr_boundary,
  input  logic [ADDR_W-1:0] pc_next,
  input  logic              iret,
  output logic              IACK,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] epc,
  output logic              in_service,
  output logic [1:0]        depth,
  output logic [CNT_W-1:0]  int_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACK     = 3'd1,
    S_VECTOR  = 3'd2,
    S_SERVICE = 3'd3,
    S_RETURN  = 3'd4
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [ADDR_W-1:0] vec_r;
  logic [ADDR_W-1:0] stack_r [2];
  logic [1:0]        depth_r;
  logic [CNT_W-1:0]  count_r;
  logic              accept_s;
  logic              nest_ok_s;
  logic              push_s;
  logic              pop_s;
  logic [ADDR_W-1:0] epc_s;

  assign accept_s = IRQ & int_en & instr_boundary;

`ifdef INTC_RESP_NEST_EN
  assign nest_ok_s = (depth_r == 2'd1);
`else
  assign nest_ok_s = 1'b0;
`endif

  // Top of stack: depth 1 -> entry 0, depth 2 -> entry 1
  assign epc_s = (depth_r == 2'd0) ? {ADDR_W{1'b0}} : stack_r[depth_r[1]];

  // Next-state decode and push/pop strobes
  always_comb begin
    state_next_s = state_r;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          push_s       = 1'b1;
          state_next_s = S_ACK;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_ACK:    state_next_s = S_VECTOR;
      S_VECTOR: state_next_s = S_SERVICE;
      S_SERVICE: begin
        if (iret) begin
          state_next_s = S_RETURN;
        end else if (accept_s && nest_ok_s) begin
          push_s       = 1'b1;
          state_next_s = S_ACK;
        end else begin
          state_next_s = S_SERVICE;
        end
      end
      S_RETURN: begin
        pop_s        = 1'b1;
        state_next_s = (depth_r > 2'd1) ? S_SERVICE : S_IDLE;
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // State, vector, return stack, nesting depth and taken counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      vec_r      <= {ADDR_W{1'b0}};
      stack_r[0] <= {ADDR_W{1'b0}};
      stack_r[1] <= {ADDR_W{1'b0}};
      depth_r    <= 2'd0;
      count_r    <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      if (push_s) begin
        stack_r[depth_r[0]] <= pc_next;
        vec_r               <= isr_addr;
        depth_r             <= depth_r + 2'd1;
        count_r             <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (pop_s) begin
        depth_r <= depth_r - 2'd1;
      end
    end
  end

  // Moore output decode from state and registers
  always_comb begin
    IACK        = (state_r == S_ACK);
    redirect    = (state_r == S_VECTOR) || (state_r == S_RETURN);
    redirect_pc = {ADDR_W{1'b0}};
    case (state_r)
      S_VECTOR: redirect_pc = vec_r;
      S_RETURN: redirect_pc = epc_s;
      default:  redirect_pc = {ADDR_W{1'b0}};
    endcase
  end

  assign epc        = epc_s;
  assign in_service = (depth_r != 2'd0);
  assign depth      = depth_r;
  assign int_count  = count_r;

endmodule

// File: tb/tb_intc_responder.sv
// Directed self-checking bench for intc_responder; nesting expectations follow INTC_RESP_NEST_EN.
module tb_intc_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        IRQ;
  logic [31:0] isr_addr;
  logic        int_en;
  logic        instr_boundary;
  logic [31:0] pc_next;
  logic        iret;
  logic        IACK;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] epc;
  logic        in_service;
  logic [1:0]  depth;
  logic [7:0]  int_count;

  int errors = 0;
  int checks = 0;

  intc_responder dut (
    .clk(clk), .rst(rst), .IRQ(IRQ), .isr_addr(isr_addr), .int_en(int_en),
    .instr_boundary(instr_boundary), .pc_next(pc_next), .iret(iret),
    .IACK(IACK), .redirect(redirect), .redirect_pc(redirect_pc), .epc(epc),
    .in_service(in_service), .depth(depth), .int_count(int_count)
  );

  always #5 clk = ~clk;

  // Outputs are sampled and inputs changed on the falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic enter(input logic [31:0] pc, input logic [31:0] isr);
    IRQ = 1'b1; pc_next = pc; isr_addr = isr;
    tick();
    IRQ = 1'b0;
    tick();
    tick();
  endtask

  task automatic leave();
    iret = 1'b1;
    tick();
    iret = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; IRQ = 1'b1; isr_addr = 32'hdead_beef; int_en = 1'b1;
    instr_boundary = 1'b1; pc_next = 32'h1234_5678; iret = 1'b1;
    tick();
    tick();
    checks++;
    if ({IACK, redirect, redirect_pc, epc, in_service, depth, int_count} !== 77'd0) begin
      errors++;
      $display("FAIL reset_outputs: got iack=%b redir=%b rpc=%h epc=%h insvc=%b depth=%0d cnt=%0d expected all 0",
               IACK, redirect, redirect_pc, epc, in_service, depth, int_count);
    end
    IRQ = 1'b0; iret = 1'b0; rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_entry();
    IRQ = 1'b1; isr_addr = 32'h400; pc_next = 32'h100;
    tick();
    IRQ = 1'b0; isr_addr = 32'h999;
    checks++;
    if ({IACK, redirect, in_service, depth, int_count} !== {1'b1, 1'b0, 1'b1, 2'd1, 8'd1}) begin
      errors++;
      $display("FAIL entry_ack: got iack=%b redir=%b insvc=%b depth=%0d cnt=%0d expected 1 0 1 1 1",
               IACK, redirect, in_service, depth, int_count);
    end
    tick();
    checks++;
    if ({IACK, redirect, redirect_pc} !== {1'b0, 1'b1, 32'h400}) begin
      errors++;
      $display("FAIL entry_vector: got iack=%b redir=%b rpc=%h expected 0 1 00000400", IACK, redirect, redirect_pc);
    end
    tick();
    checks++;
    if ({IACK, redirect, in_service, epc, int_count} !== {1'b0, 1'b0, 1'b1, 32'h100, 8'd1}) begin
      errors++;
      $display("FAIL entry_service: got iack=%b redir=%b insvc=%b epc=%h cnt=%0d expected 0 0 1 00000100 1",
               IACK, redirect, in_service, epc, int_count);
    end
  endtask

  task automatic test_return();
    iret = 1'b1;
    tick();
    iret = 1'b0;
    checks++;
    if ({redirect, redirect_pc, IACK} !== {1'b1, 32'h100, 1'b0}) begin
      errors++;
      $display("FAIL return_redirect: got redir=%b rpc=%h iack=%b expected 1 00000100 0", redirect, redirect_pc, IACK);
    end
    tick();
    checks++;
    if ({redirect, depth, epc, in_service} !== {1'b0, 2'd0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL return_idle: got redir=%b depth=%0d epc=%h insvc=%b expected 0 0 0 0", redirect, depth, epc, in_service);
    end
  endtask

  task automatic test_gating();
    for (int g = 0; g < 2; g++) begin
      int_en = (g == 0) ? 1'b0 : 1'b1;
      instr_boundary = (g == 0) ? 1'b1 : 1'b0;
      IRQ = 1'b1; isr_addr = 32'h600; pc_next = 32'h200;
      for (int i = 0; i < 10; i++) begin
        tick();
        checks++;
        if ({IACK, redirect, depth} !== 4'd0) begin
          errors++;
          $display("FAIL gating_blocked: case=%0d cycle=%0d got iack=%b redir=%b depth=%0d expected 0 0 0", g, i, IACK, redirect, depth);
        end
      end
      int_en = 1'b1; instr_boundary = 1'b1;
      tick();
      IRQ = 1'b0;
      checks++;
      if (IACK !== 1'b1) begin
        errors++;
        $display("FAIL gating_release: case=%0d got iack=%b expected 1", g, IACK);
      end
      tick();
      checks++;
      if ({IACK, redirect, redirect_pc} !== {1'b0, 1'b1, 32'h600}) begin
        errors++;
        $display("FAIL gating_vector: case=%0d got iack=%b redir=%b rpc=%h expected 0 1 00000600", g, IACK, redirect, redirect_pc);
      end
      tick();
      leave();
    end
  endtask

  task automatic test_nesting();
    enter(32'h100, 32'h400);
    IRQ = 1'b1; isr_addr = 32'h500; pc_next = 32'h420;
    tick();
`ifdef INTC_RESP_NEST_EN
    IRQ = 1'b0;
    checks++;
    if ({IACK, depth} !== {1'b1, 2'd2}) begin
      errors++;
      $display("FAIL nest_ack: got iack=%b depth=%0d expected 1 2", IACK, depth);
    end
    tick();
    checks++;
    if ({redirect, redirect_pc} !== {1'b1, 32'h500}) begin
      errors++;
      $display("FAIL nest_vector: got redir=%b rpc=%h expected 1 00000500", redirect, redirect_pc);
    end
    tick();
    IRQ = 1'b1; isr_addr = 32'h700;
    checks++;
    if ({epc, depth} !== {32'h420, 2'd2}) begin
      errors++;
      $display("FAIL nest_epc: got epc=%h depth=%0d expected 00000420 2", epc, depth);
    end
    tick();
    IRQ = 1'b0;
    checks++;
    if ({IACK, depth} !== {1'b0, 2'd2}) begin
      errors++;
      $display("FAIL nest_full_ignored: got iack=%b depth=%0d expected 0 2", IACK, depth);
    end
    iret = 1'b1;
    tick();
    iret = 1'b0;
    checks++;
    if ({redirect, redirect_pc} !== {1'b1, 32'h420}) begin
      errors++;
      $display("FAIL nest_ret1: got redir=%b rpc=%h expected 1 00000420", redirect, redirect_pc);
    end
    tick();
    checks++;
    if ({redirect, depth, epc, in_service} !== {1'b0, 2'd1, 32'h100, 1'b1}) begin
      errors++;
      $display("FAIL nest_mid: got redir=%b depth=%0d epc=%h insvc=%b expected 0 1 00000100 1", redirect, depth, epc, in_service);
    end
`else
    checks++;
    if ({IACK, depth, epc} !== {1'b0, 2'd1, 32'h100}) begin
      errors++;
      $display("FAIL nest_ignored: got iack=%b depth=%0d epc=%h expected 0 1 00000100", IACK, depth, epc);
    end
    tick();
    IRQ = 1'b0;
    checks++;
    if ({IACK, redirect, depth} !== {1'b0, 1'b0, 2'd1}) begin
      errors++;
      $display("FAIL nest_ignored_hold: got iack=%b redir=%b depth=%0d expected 0 0 1", IACK, redirect, depth);
    end
`endif
    iret = 1'b1;
    tick();
    iret = 1'b0;
    checks++;
    if ({redirect, redirect_pc} !== {1'b1, 32'h100}) begin
      errors++;
      $display("FAIL nest_ret_outer: got redir=%b rpc=%h expected 1 00000100", redirect, redirect_pc);
    end
    tick();
    checks++;
    if ({depth, in_service} !== {2'd0, 1'b0}) begin
      errors++;
      $display("FAIL nest_done: got depth=%0d insvc=%b expected 0 0", depth, in_service);
    end
  endtask

  task automatic test_simultaneous();
    enter(32'h140, 32'h480);
    iret = 1'b1; IRQ = 1'b1; isr_addr = 32'h500; pc_next = 32'h444;
    tick();
    iret = 1'b0; IRQ = 1'b0;
    checks++;
    if ({IACK, redirect, redirect_pc} !== {1'b0, 1'b1, 32'h140}) begin
      errors++;
      $display("FAIL simul_return: got iack=%b redir=%b rpc=%h expected 0 1 00000140", IACK, redirect, redirect_pc);
    end
    tick();
    checks++;
    if ({IACK, depth} !== {1'b0, 2'd0}) begin
      errors++;
      $display("FAIL simul_idle: got iack=%b depth=%0d expected 0 0", IACK, depth);
    end
  endtask

  task automatic test_reset_mid();
    IRQ = 1'b1; isr_addr = 32'h800; pc_next = 32'h300;
    tick();
    IRQ = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({IACK, redirect, redirect_pc, epc, in_service, depth, int_count} !== 77'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got iack=%b redir=%b rpc=%h epc=%h insvc=%b depth=%0d cnt=%0d expected all 0",
               IACK, redirect, redirect_pc, epc, in_service, depth, int_count);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({IACK, redirect, depth} !== 4'd0) begin
        errors++;
        $display("FAIL reset_mid_no_replay: cycle=%0d got iack=%b redir=%b depth=%0d expected 0 0 0", i, IACK, redirect, depth);
      end
    end
  endtask

  task automatic test_wrap();
    for (int n = 0; n < 255; n++) begin
      enter(32'h100 + n, 32'h400 + n);
      leave();
    end
    checks++;
    if (int_count !== 8'd255) begin
      errors++;
      $display("FAIL wrap_255: got cnt=%0d expected 255", int_count);
    end
    enter(32'h100, 32'h400);
    checks++;
    if ({int_count, depth} !== {8'd0, 2'd1}) begin
      errors++;
      $display("FAIL wrap_zero: got cnt=%0d depth=%0d expected 0 1", int_count, depth);
    end
    leave();
  endtask

  initial begin
    test_reset();
    test_basic_entry();
    test_return();
    test_gating();
    test_nesting();
    test_simultaneous();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
